// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 7-segment display driver.
// Scans digits MSD first, one slot of CLK_DIV cycles each, with leading-zero
// blanking, per-digit blink, per-digit decimal point and 4-level brightness.
// Display inputs are captured once per frame so a frame is never torn.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 100000,
  parameter int BLINK_DIV  = 250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [1:0]              bright,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int SLOT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int QUARTER = CLK_DIV / 4;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    blank_lz;
    logic [1:0]              bright;
  } shadow_t;

  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic                  phase_q, phase_d;
  logic                  load_q;
  shadow_t               shadow_q, shadow_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  shadow_t               shadow_in;
  shadow_t               cur;
  logic                  slot_last;
  logic                  frame_wrap;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_run;
  logic [3:0]            cur_digit;
  logic [31:0]           lit_limit;
  logic                  lit;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    // Active-low {g,f,e,d,c,b,a}; non-BCD codes render dark.
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign shadow_in  = '{digits: digits, blink_mask: blink_mask, dp_mask: dp_mask,
                        blank_lz: blank_lz, bright: bright};
  assign slot_last  = (slot_q == SLOT_W'(CLK_DIV - 1));
  assign frame_wrap = en && slot_last && (idx_q == '0);

  // Next-state for scan counters, blink timing and the per-frame input snapshot.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    slot_d   = slot_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    phase_d  = phase_q;
    shadow_d = shadow_q;
    if (load_q || frame_wrap) shadow_d = shadow_in;
    if (en) begin
      slot_d = slot_last ? '0 : slot_q + SLOT_W'(1);
      if (slot_last) idx_d = (idx_q == '0) ? IDX_W'(NUM_DIGITS - 1) : idx_q - IDX_W'(1);
      if (frame_wrap) begin
        if (frame_q == FRAME_W'(BLINK_DIV - 1)) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + FRAME_W'(1);
        end
      end
    end
  end

  // Output decode for the current slot; registered below so outputs lag state by one cycle.
  always_comb begin
    // Right after reset the snapshot is being taken this very cycle, so show the live
    // inputs; otherwise the first slot of the first frame would display zeros.
    cur      = load_q ? shadow_in : shadow_q;
    lz_blank = '0;
    zero_run = cur.blank_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run && (cur.digits[4*k +: 4] == 4'd0);
      lz_blank[k] = zero_run;
    end
    cur_digit = cur.digits[4*idx_q +: 4];
    lit_limit = (32'(cur.bright) + 32'd1) * 32'(QUARTER);
    // Dimmed-off portion of a slot blanks segments and dp too, so nothing ghosts onto
    // the next digit when its anode switches on.
    lit = en && !lz_blank[idx_q] && !(phase_q && cur.blink_mask[idx_q])
          && (32'(slot_q) < lit_limit);
    seg_d        = 7'b1111111;
    dp_d         = 1'b1;
    an_d         = '1;
    frame_done_d = frame_wrap;
    if (lit) begin
      seg_d        = bcd_to_seg(cur_digit);
      dp_d         = ~cur.dp_mask[idx_q];
      an_d[idx_q]  = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      slot_q       <= '0;
      idx_q        <= IDX_W'(NUM_DIGITS - 1);
      frame_q      <= '0;
      phase_q      <= 1'b0;
      load_q       <= 1'b1;
      shadow_q     <= '0;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      phase_q      <= phase_d;
      load_q       <= 1'b0;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Testbench for seg_scan_mux (NUM_DIGITS=4, CLK_DIV=4, BLINK_DIV=2).
// Expected outputs come from a time-based model: position in the scan is derived
// from the count of enabled cycles since reset, and inputs are snapshotted per frame.
module tb_seg_scan_mux;

  localparam int ND    = 4;
  localparam int CDIV  = 4;
  localparam int BDIV  = 2;
  localparam int FRAME = ND * CDIV;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [4*ND-1:0] digits = '0;
  logic          blank_lz = 1'b0;
  logic [ND-1:0] blink_mask = '0;
  logic [ND-1:0] dp_mask = '0;
  logic [1:0]    bright = 2'd0;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;
  logic          frame_done;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int         t = 0;
  bit         need_load = 1'b1;
  logic [3:0] sh_dig [ND];
  bit         sh_blink [ND];
  bit         sh_dp [ND];
  bit         sh_lz;
  int         sh_bright;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  seg_scan_mux #(.NUM_DIGITS(ND), .CLK_DIV(CDIV), .BLINK_DIV(BDIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .bright     (bright),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic snapshot();
    for (int k = 0; k < ND; k++) begin
      sh_dig[k]   = digits[4*k +: 4];
      sh_blink[k] = blink_mask[k];
      sh_dp[k]    = dp_mask[k];
    end
    sh_lz     = blank_lz;
    sh_bright = int'(bright);
  endtask

  task automatic clear_shadow();
    for (int k = 0; k < ND; k++) begin
      sh_dig[k]   = 4'd0;
      sh_blink[k] = 1'b0;
      sh_dp[k]    = 1'b0;
    end
    sh_lz     = 1'b0;
    sh_bright = 0;
  endtask

  // One clock edge: predict the registered outputs, then compare just after the edge.
  task automatic step();
    logic [6:0]    e_seg;
    logic          e_dp;
    logic [ND-1:0] e_an;
    logic          e_fd;
    int            slot, d, frame;
    bit            phase, lzb, lit;
    @(posedge clk);
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    e_an  = '1;
    e_fd  = 1'b0;
    if (!rst) begin
      t = 0;
      need_load = 1'b1;
      clear_shadow();
    end else begin
      if (need_load) begin
        snapshot();
        need_load = 1'b0;
      end
      if (en) begin
        slot  = t % CDIV;
        d     = ND - 1 - (t / CDIV) % ND;
        frame = t / FRAME;
        phase = ((frame / BDIV) % 2) == 1;
        lzb   = sh_lz && (d != 0);
        for (int j = d; j < ND; j++) if (sh_dig[j] != 4'd0) lzb = 1'b0;
        lit = !lzb && !(phase && sh_blink[d]) && (slot < (sh_bright + 1) * (CDIV / 4));
        if (lit) begin
          e_an[d] = 1'b0;
          e_seg   = (sh_dig[d] < 4'd10) ? seg_tab[sh_dig[d]] : 7'b1111111;
          e_dp    = !sh_dp[d];
        end
        e_fd = (t % FRAME) == FRAME - 1;
        if (e_fd) snapshot();
        t++;
      end
    end
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("an", 32'(an), 32'(e_an));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("one_anode", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    clear_shadow();
    // Reset state
    rst = 1'b0;
    run(2);

    // Plain count 1234 at full brightness
    digits = 16'h1234; bright = 2'd3; en = 1'b1; rst = 1'b1;
    step();
    check("first_an", 32'(an), 32'(4'b0111));
    check("first_seg", 32'(seg), 32'(7'b1111001));
    run(31);
    check("frame_done_2nd", 32'(frame_done), 32'd1);

    // Leading-zero blanking
    digits = 16'h0070; blank_lz = 1'b1;
    run(48);
    digits = 16'h0000;
    run(32);

    // Blink on digit 0 across six frames, with decimal points
    blank_lz = 1'b0; digits = 16'h1234; blink_mask = 4'b0001; dp_mask = 4'b0101;
    run(96);

    // Brightness levels
    blink_mask = '0; dp_mask = '0; bright = 2'd0;
    run(32);
    bright = 2'd1;
    run(32);

    // Mid-frame input change, then a non-BCD code
    bright = 2'd3;
    run(6);
    digits = 16'h5678;
    run(26);
    digits = 16'h00A0;
    run(32);

    // Reset mid-frame abandons the frame
    run(5);
    rst = 1'b0;
    step();
    check("rst_an", 32'(an), 32'(4'hF));
    check("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b1;
    run(7);

    // Enable low holds counters and darkens the display
    en = 1'b0;
    run(10);
    check("en0_an", 32'(an), 32'(4'hF));
    en = 1'b1;
    run(20);

    // Randomized inputs, changed every cycle
    for (int i = 0; i < 700; i++) begin
      for (int k = 0; k < ND; k++)
        digits[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      blank_lz   = 1'($urandom_range(0, 1));
      blink_mask = ND'($urandom);
      dp_mask    = ND'($urandom);
      bright     = 2'($urandom);
      en         = ($urandom_range(0, 15) != 0);
      rst        = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
